// File: rtl/dflop_pkg.sv
// Shared constants and helpers for the dflop_pipe delay line.
// Stage word layout is {valid, data[WIDTH-1:0]}, valid in the MSB.
package dflop_pkg;

    localparam logic CLR_ACTIVE = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int stage_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/dflop_pipe_if.sv
// Data/control bundle between a pipeline client and a dflop_pipe instance.
interface dflop_pipe_if
    import dflop_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_1;
    logic             in_valid;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] out_1;
    logic             out_valid;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;

    modport master (
        output in_1, in_valid, enable, clear,
        input  out_1, out_valid, occupancy, full, empty
    );

    modport slave (
        input  in_1, in_valid, enable, clear,
        output out_1, out_valid, occupancy, full, empty
    );
endinterface

// File: rtl/dflop_stage.sv
// One {valid, data} pipeline register: async reset, sync active-low clear, enable.
module dflop_stage
    import dflop_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic [stage_w(WIDTH)-1:0] d_i,
    output logic [stage_w(WIDTH)-1:0] q_o
);
    localparam int SW = stage_w(WIDTH);

    logic [SW-1:0] stage_q;
    logic [SW-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clear_i == CLR_ACTIVE) begin
            stage_d = '0;
        end else if (enable_i) begin
            stage_d = d_i;
            // Bubbles carry zero data so stale values never leak downstream.
            if (ZERO_INVALID && !d_i[WIDTH]) begin
                stage_d[WIDTH-1:0] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;
endmodule

// File: rtl/dflop_pipe.sv
// WIDTH x DEPTH stall-capable delay line with per-stage valid and occupancy count.
module dflop_pipe
    import dflop_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    dflop_pipe_if.slave  bus
);
    localparam int SW    = stage_w(WIDTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [SW-1:0]    st_q [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             out_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            dflop_stage #(.WIDTH(WIDTH), .ZERO_INVALID(ZERO_INVALID)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .clear_i  (bus.clear),
                .enable_i (bus.enable),
                .d_i      ({bus.in_valid, bus.in_1}),
                .q_o      (st_q[k])
            );
        end else begin : g_next
            dflop_stage #(.WIDTH(WIDTH), .ZERO_INVALID(ZERO_INVALID)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .clear_i  (bus.clear),
                .enable_i (bus.enable),
                .d_i      (st_q[k-1]),
                .q_o      (st_q[k])
            );
        end
        assign valid_vec[k] = st_q[k][WIDTH];
    end

    assign out_valid = st_q[DEPTH-1][WIDTH];

    // One in and one out per advance, so the count stays within 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (bus.clear == CLR_ACTIVE) begin
            occ_d = '0;
        end else if (bus.enable) begin
            occ_d = occ_q + CNT_W'(bus.in_valid) - CNT_W'(out_valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.out_1     = st_q[DEPTH-1][WIDTH-1:0];
    assign bus.out_valid = out_valid;
    assign bus.occupancy = occ_q;
    assign bus.full      = (occ_q == CNT_W'(DEPTH));
    assign bus.empty     = (occ_q == '0);

`ifndef SYNTHESIS
    occ_matches_valids: assert property (@(posedge clk) disable iff (reset)
        occ_q == CNT_W'($countones(valid_vec)));
`endif
endmodule

// File: doc/dflop_pipe.md
Name: dflop_pipe

Overview:
- Parametrised successor to the single-bit enabled/cleared D-flop.
- A WIDTH-bit, DEPTH-stage registered delay line with a per-stage valid bit, a global advance enable (stall), a synchronous active-low clear, and an occupancy counter.
- Used to retime and align data paths across stall-capable pipeline sections.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of register stages, equal to latency in enabled cycles (>=1).
- ZERO_INVALID, 1: 1 = stage data forced to 0 whenever its valid is 0; 0 = data captured regardless of valid.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_1  input  WIDTH  data into stage 0.
- in_valid  input  1  qualifies in_1.
- enable  input  1  1 = all stages advance this cycle; 0 = hold (stall).
- clear  input  1  synchronous, active-low; 0 empties the pipe.
- out_1  output  WIDTH  data of stage DEPTH-1 (registered).
- out_valid  output  1  valid of stage DEPTH-1.
- occupancy  output  CNT_W  count of valid stages, 0..DEPTH.
- full  output  1  occupancy == DEPTH (combinational from registered count).
- empty  output  1  occupancy == 0.

Behaviour:
- Priority per rising clk edge: reset (async) > clear==0 > enable==1 > hold.
- Reset asserted:
  - all stage data = 0, all valid = 0, occupancy = 0.
  - Hence out_1 = 0, out_valid = 0, empty = 1, full = 0 immediately, without waiting for a clock edge.
  - Reset mid-stream discards all in-flight entries.
- clear==0 (reset low): same state as reset, taken at the next edge. Overrides enable; in_1/in_valid presented that cycle are dropped.
- enable==1, clear==1:
  - stage0 <= {in_valid, in_1}; stage[k] <= stage[k-1] for k=1..DEPTH-1.
  - The stage DEPTH-1 entry leaves the pipe.
  - ZERO_INVALID=1: a stage loaded with valid=0 gets data 0.
- enable==0, clear==1: all stages and occupancy hold. in_1 is ignored even when in_valid=1; the caller owns backpressure.
- Latency: an entry accepted at enabled edge N appears on out_1/out_valid after the DEPTH-th enabled edge counting from N. Stalled cycles do not count.
- Occupancy, on an advancing edge only:
  - next = occupancy + in_valid - out_valid (out_valid = pre-edge value of stage DEPTH-1).
  - Simultaneous enter and exit leaves the count unchanged.
  - Never exceeds DEPTH or drops below 0 by construction.
  - Assertion: occupancy always equals the popcount of the stage valid bits.
- DEPTH==1: a single stage; out_1 follows in_1 one enabled edge later. Same enable/clear semantics as the original flop, extended by WIDTH and valid.
- No combinational path from any input to any output; full/empty are decoded from the occupancy register.

Decomposition:
- Shared package dflop_pkg:
  - function clog2 for CNT_W.
  - localparam-friendly constant CLR_ACTIVE = 1'b0 (clear polarity).
  - typedef-equivalent packed stage layout {valid, data[WIDTH-1:0]}.
- Sub-module dflop_stage (parameter WIDTH, ZERO_INVALID):
  - one {valid, data} register with async reset, sync active-low clear and enable.
  - Instantiated DEPTH times in a generate loop.
- Occupancy counter and full/empty decode live in the top module.

Test Plan:
- Reset: assert reset mid-clock with the pipe full (occupancy=4) -> out_valid=0, out_1=0, occupancy=0, empty=1 before the next edge.
- Latency (WIDTH=8, DEPTH=4): enable=1, in_valid=1, drive 0x11,0x22,0x33,0x44,0x55 on consecutive edges -> out_1=0x11 with out_valid=1 after the 4th edge, then 0x22..0x55 each following cycle. occupancy steps 1,2,3,4,4; full=1 from the 4th edge.
- Stall: after 2 entries, hold enable=0 for 5 cycles while toggling in_1=0xFF, in_valid=1 -> outputs and occupancy=2 frozen. Resume -> 0x11 exits 2 enabled edges later; 0xFF never appears.
- Clear priority: with occupancy=3, drive clear=0, enable=1, in_valid=1, in_1=0xAA for one edge -> occupancy=0, out_valid=0, 0xAA never emerges.
- Bubbles with ZERO_INVALID=1: input pattern valid 1,0,1 with data 0x01,0x5A,0x03 -> outputs 0x01/v1, 0x00/v0, 0x03/v1. Repeat with ZERO_INVALID=0 -> middle beat 0x5A/v0.
- Steady-state throughput: continuous valid with enable=1 for 20 cycles at DEPTH=1 and DEPTH=8 -> occupancy stays at DEPTH once filled; output sequence matches input sequence delayed by DEPTH.
